riscv_branch_predictor: RTL and testbench
=========================================

Name: riscv_branch_predictor

Overview:
Parametrised branch-prediction and control-hazard unit for the pipelined RISC-V core. It replaces the fixed "predict not-taken, flush on taken" scheme with a direct-mapped branch target buffer (BTB) holding saturating direction counters. Fetch (F) looks up the current PC. Execute (E) resolves each branch or jump, updates the BTB, and raises flush/redirect on a mispredict. MODE=0 reproduces the existing static not-taken behaviour exactly.

Parameters:
XLEN, 32, address/data width
ENTRIES, 16, BTB entries; power of 2, at least 2; IDX_W = log2(ENTRIES)
CNT_BITS, 2, saturating direction counter width, at least 1
MODE, 1, 0 = static not-taken, 1 = dynamic BTB prediction
STAT_W, 16, mispredict statistics counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
f_pc  in  XLEN  fetch-stage PC
f_pred_taken  out  1  prediction for f_pc
f_pred_target  out  XLEN  predicted target; 0 when f_pred_taken=0
e_valid  in  1  a branch or jump resolves in E this cycle
e_is_jump  in  1  unconditional (jal/jalr)
e_pc  in  XLEN  PC of the resolving instruction
e_taken  in  1  actual direction
e_target  in  XLEN  actual target
e_pred_taken  in  1  prediction piped from F
e_pred_target  in  XLEN  predicted target piped from F
flush  out  1  flush F/D, squash wrong-path instructions
redirect_pc  out  XLEN  next fetch PC when flush=1
stat_mispredicts  out  STAT_W  count of mispredicts

Behaviour:
- Indexing: idx = pc[IDX_W+1:2], tag = pc[XLEN-1:IDX_W+2]. Each entry holds valid, tag, target, jump bit and cnt[CNT_BITS-1:0].
- Reset (rst=0, asynchronous): all valid bits cleared; cnt = weakly not-taken, value 2^(CNT_BITS-1)-1; stat_mispredicts=0. Outputs during reset: f_pred_taken=0, f_pred_target=0, flush=0, redirect_pc=0. Asserting reset mid-operation takes effect immediately, with no clock edge needed.
- Lookup (combinational, zero latency):
  - hit = valid & (tag match).
  - MODE=1: f_pred_taken = hit & (jump bit | cnt MSB); f_pred_target = entry target when f_pred_taken=1.
  - MODE=0: f_pred_taken is constantly 0.
- Mispredict (combinational, same cycle as E):
  - flush = e_valid & ((e_taken != e_pred_taken) | (e_taken & e_pred_taken & e_target != e_pred_target)).
  - redirect_pc = e_taken ? e_target : e_pc+4 (modulo 2^XLEN). redirect_pc is 0 when flush=0.
- Update (rising edge, e_valid=1, MODE=1 only):
  - Hit, e_taken=1: cnt increments, saturating at all-ones; target <= e_target; jump bit <= e_is_jump.
  - Hit, e_taken=0: cnt decrements, saturating at 0.
  - Miss, e_taken=1: allocate and overwrite any aliasing entry; valid=1, tag, target, jump bit; cnt = weakly taken, value 2^(CNT_BITS-1).
  - Miss, e_taken=0: no change.
- Same-index lookup and update in one cycle: lookup returns pre-update contents (read before write). The update becomes visible on the next cycle.
- stat_mispredicts: increments at each edge where flush=1; saturates at all-ones; counts in both modes.
- e_valid=0: no update and no flush, regardless of the other E inputs.
- The unit has no stall input. The core holds e_valid low while E is stalled.

Test Plan:
1. MODE=1, after reset, f_pc=0x0 gives f_pred_taken=0. Then e_valid: beq at e_pc=0x0, taken, target 0x14, pred 0 → flush=1, redirect_pc=0x14, and after the edge stat_mispredicts=1.
2. Next cycle f_pc=0x0 → f_pred_taken=1, f_pred_target=0x14. Resolve taken to 0x14 with pred 1/0x14 → flush=0, cnt 10→11.
3. Three not-taken resolves at 0x0 → cnt 11→10→01→00. f_pred_taken stays 1 after the first and is 0 after the second. Flush fires with redirect_pc=0x4 on the first two resolves only. The third holds cnt at 00, with no flush.
4. Aliasing (ENTRIES=16): with the entry for 0x0 valid, f_pc=0x40 → no hit, pred 0. A taken resolve at 0x40 to 0x80 replaces the entry; f_pc=0x0 then misses.
5. jalr at 0x8, predicted taken to 0x20, actually goes to 0x30 → flush=1, redirect_pc=0x30; the entry target becomes 0x30. A lookup of 0x8 in the same cycle still returns 0x20.
6. MODE=0: repeat the scenario 1 resolve twice → flush both times, f_pred_taken always 0, stat_mispredicts=2. Then pulse rst low mid-cycle → stat_mispredicts=0 at once, and all entries are invalid in MODE=1.

Source files
------------

// File: rtl/riscv_branch_predictor.sv
// ---------------------------------------------------------------------------
// riscv_branch_predictor
//
// Branch-prediction and control-hazard unit for the pipelined RISC-V core.
// A direct-mapped branch target buffer (BTB) is looked up combinationally by
// the fetch stage. Each entry holds a saturating direction counter. Branches
// and jumps resolving in execute update the BTB on the rising clock edge. A
// wrong direction or a wrong target raises flush and supplies the corrected
// fetch PC. With MODE=0 the unit always predicts not-taken, never allocates
// entries and flushes on every taken branch, like the old static scheme.
//
// Parameters
//   XLEN     address/data width
//   ENTRIES  BTB entries (power of 2, >= 2)
//   CNT_BITS direction counter width (>= 1)
//   MODE     0 = static not-taken, 1 = dynamic BTB prediction
//   STAT_W   width of the mispredict statistics counter
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous active-low reset
//   f_pc             fetch-stage PC
//   f_pred_taken     predicted direction for f_pc
//   f_pred_target    predicted target (0 when not predicted taken)
//   e_valid          a branch/jump resolves in execute this cycle
//   e_is_jump        resolving instruction is unconditional (jal/jalr)
//   e_pc             PC of the resolving instruction
//   e_taken          actual direction
//   e_target         actual target
//   e_pred_taken     prediction carried down from fetch
//   e_pred_target    predicted target carried down from fetch
//   flush            squash wrong-path instructions in F/D
//   redirect_pc      next fetch PC while flush=1, else 0
//   stat_mispredicts saturating count of flushes
// ---------------------------------------------------------------------------
module riscv_branch_predictor #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CNT_BITS = 2,
    parameter int MODE     = 1,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   f_pc,
    output logic              f_pred_taken,
    output logic [XLEN-1:0]   f_pred_target,
    input  logic              e_valid,
    input  logic              e_is_jump,
    input  logic [XLEN-1:0]   e_pc,
    input  logic              e_taken,
    input  logic [XLEN-1:0]   e_target,
    input  logic              e_pred_taken,
    input  logic [XLEN-1:0]   e_pred_target,
    output logic              flush,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [CNT_BITS-1:0] CNT_WEAK_NT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0] CNT_WEAK_T  = CNT_BITS'(1 << (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0] CNT_MAX     = '1;
    localparam logic [CNT_BITS-1:0] CNT_MIN     = '0;

    // Flattened view of the per-entry registers for the lookup muxes.
    logic                ent_valid  [ENTRIES];
    logic [TAG_W-1:0]    ent_tag    [ENTRIES];
    logic [XLEN-1:0]     ent_target [ENTRIES];
    logic                ent_jump   [ENTRIES];
    logic [CNT_BITS-1:0] ent_cnt    [ENTRIES];

    // Instructions are word aligned; the low PC bits never select anything.
    logic unused_f_pc_bits;
    assign unused_f_pc_bits = ^f_pc[1:0];

    // ---------------- Fetch lookup ----------------
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic             f_dir;

    assign f_idx = f_pc[IDX_W+1:2];
    assign f_tag = f_pc[XLEN-1:IDX_W+2];
    assign f_hit = ent_valid[f_idx] && (ent_tag[f_idx] == f_tag);
    // Jumps are always taken once seen; branches follow the counter MSB.
    assign f_dir = f_hit && (ent_jump[f_idx] || ent_cnt[f_idx][CNT_BITS-1]);

    assign f_pred_taken  = rst && (MODE == 1) && f_dir;
    assign f_pred_target = f_pred_taken ? ent_target[f_idx] : '0;

    // ---------------- Execute resolve ----------------
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_hit;
    logic             mispredict;

    assign e_idx = e_pc[IDX_W+1:2];
    assign e_tag = e_pc[XLEN-1:IDX_W+2];
    assign e_hit = ent_valid[e_idx] && (ent_tag[e_idx] == e_tag);

    assign mispredict = (e_taken != e_pred_taken) ||
                        (e_taken && e_pred_taken && (e_target != e_pred_target));

    // Gating with rst keeps the outputs quiet while reset is held.
    assign flush       = rst && e_valid && mispredict;
    assign redirect_pc = !flush ? '0 : (e_taken ? e_target : e_pc + XLEN'(4));

    // ---------------- BTB entries ----------------
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic                valid_q,  valid_d;
            logic [TAG_W-1:0]    tag_q,    tag_d;
            logic [XLEN-1:0]     target_q, target_d;
            logic                jump_q,   jump_d;
            logic [CNT_BITS-1:0] cnt_q,    cnt_d;
            logic                upd_sel;

            assign upd_sel = (MODE == 1) && e_valid && (e_idx == IDX_W'(gi));

            always_comb begin
                valid_d  = valid_q;
                tag_d    = tag_q;
                target_d = target_q;
                jump_d   = jump_q;
                cnt_d    = cnt_q;
                if (upd_sel) begin
                    if (e_hit) begin
                        if (e_taken) begin
                            cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_BITS'(1);
                            target_d = e_target;
                            jump_d   = e_is_jump;
                        end else begin
                            cnt_d    = (cnt_q == CNT_MIN) ? cnt_q : cnt_q - CNT_BITS'(1);
                        end
                    end else if (e_taken) begin
                        // Allocation simply evicts whatever aliases here.
                        valid_d  = 1'b1;
                        tag_d    = e_tag;
                        target_d = e_target;
                        jump_d   = e_is_jump;
                        cnt_d    = CNT_WEAK_T;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_q  <= 1'b0;
                    tag_q    <= '0;
                    target_q <= '0;
                    jump_q   <= 1'b0;
                    cnt_q    <= CNT_WEAK_NT;
                end else begin
                    valid_q  <= valid_d;
                    tag_q    <= tag_d;
                    target_q <= target_d;
                    jump_q   <= jump_d;
                    cnt_q    <= cnt_d;
                end
            end

            assign ent_valid[gi]  = valid_q;
            assign ent_tag[gi]    = tag_q;
            assign ent_target[gi] = target_q;
            assign ent_jump[gi]   = jump_q;
            assign ent_cnt[gi]    = cnt_q;
        end
    endgenerate

    // ---------------- Mispredict statistics ----------------
    logic [STAT_W-1:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (flush && (stat_q != '1)) begin
            stat_d = stat_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_mispredicts = stat_q;

endmodule

// File: tb/tb_riscv_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_riscv_branch_predictor
//
// Self-checking bench. Instance "a" is the dynamic predictor (MODE=1,
// default sizes), instance "b" is the static predictor (MODE=0) with a
// 2-bit statistics counter so saturation is reachable quickly.
// A table of single-cycle vectors drives instance a; each vector's expected
// outputs go into a queue when it is driven and are popped and compared on
// the following falling edge. Hand-written sequences cover reset, the
// static mode and an asynchronous mid-cycle reset.
// ---------------------------------------------------------------------------
module tb_riscv_branch_predictor;

    logic clk;
    logic rst;

    // Instance a (MODE=1)
    logic [31:0] a_f_pc, a_f_pred_target, a_e_pc, a_e_target, a_e_pred_target, a_redirect_pc;
    logic        a_f_pred_taken, a_e_valid, a_e_is_jump, a_e_taken, a_e_pred_taken, a_flush;
    logic [15:0] a_stat;

    // Instance b (MODE=0)
    logic [31:0] b_f_pc, b_f_pred_target, b_e_pc, b_e_target, b_e_pred_target, b_redirect_pc;
    logic        b_f_pred_taken, b_e_valid, b_e_is_jump, b_e_taken, b_e_pred_taken, b_flush;
    logic [1:0]  b_stat;

    riscv_branch_predictor #(
        .XLEN(32), .ENTRIES(16), .CNT_BITS(2), .MODE(1), .STAT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst),
        .f_pc(a_f_pc), .f_pred_taken(a_f_pred_taken), .f_pred_target(a_f_pred_target),
        .e_valid(a_e_valid), .e_is_jump(a_e_is_jump), .e_pc(a_e_pc),
        .e_taken(a_e_taken), .e_target(a_e_target),
        .e_pred_taken(a_e_pred_taken), .e_pred_target(a_e_pred_target),
        .flush(a_flush), .redirect_pc(a_redirect_pc), .stat_mispredicts(a_stat)
    );

    riscv_branch_predictor #(
        .XLEN(32), .ENTRIES(16), .CNT_BITS(2), .MODE(0), .STAT_W(2)
    ) dut_b (
        .clk(clk), .rst(rst),
        .f_pc(b_f_pc), .f_pred_taken(b_f_pred_taken), .f_pred_target(b_f_pred_target),
        .e_valid(b_e_valid), .e_is_jump(b_e_is_jump), .e_pc(b_e_pc),
        .e_taken(b_e_taken), .e_target(b_e_target),
        .e_pred_taken(b_e_pred_taken), .e_pred_target(b_e_pred_target),
        .flush(b_flush), .redirect_pc(b_redirect_pc), .stat_mispredicts(b_stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] f_pc;
        logic        ev;
        logic        ej;
        logic [31:0] epc;
        logic        et;
        logic [31:0] etgt;
        logic        ept;
        logic [31:0] eptgt;
        logic        xpt;
        logic [31:0] xptgt;
        logic        xfl;
        logic [31:0] xrd;
        logic [15:0] xst;
    } vec_t;

    function automatic vec_t mk(
        input logic [31:0] f_pc, input logic ev, input logic ej, input logic [31:0] epc,
        input logic et, input logic [31:0] etgt, input logic ept, input logic [31:0] eptgt,
        input logic xpt, input logic [31:0] xptgt, input logic xfl, input logic [31:0] xrd,
        input logic [15:0] xst);
        vec_t v;
        v.f_pc = f_pc; v.ev = ev; v.ej = ej; v.epc = epc; v.et = et; v.etgt = etgt;
        v.ept = ept; v.eptgt = eptgt; v.xpt = xpt; v.xptgt = xptgt; v.xfl = xfl;
        v.xrd = xrd; v.xst = xst;
        return v;
    endfunction

    localparam int NVEC = 21;
    vec_t vecs [NVEC];
    vec_t exp_q [$];

    // Watchdog: the bench is purely clock-counted, this only guards a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t x;

        //             f_pc          ev ej e_pc          et e_tgt         ept e_ptgt     | pt tgt         fl redirect      stat
        vecs[0]  = mk(32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      0, 32'h0,      0, 32'h0,      0);
        vecs[1]  = mk(32'h0,         1, 0, 32'h0,        1, 32'h14,       0, 32'h0,      0, 32'h0,      1, 32'h14,     0);
        vecs[2]  = mk(32'h0,         1, 0, 32'h0,        1, 32'h14,       1, 32'h14,     1, 32'h14,     0, 32'h0,      1);
        vecs[3]  = mk(32'h0,         1, 0, 32'h0,        0, 32'h0,        1, 32'h14,     1, 32'h14,     1, 32'h4,      1);
        vecs[4]  = mk(32'h0,         1, 0, 32'h0,        0, 32'h0,        1, 32'h14,     1, 32'h14,     1, 32'h4,      2);
        vecs[5]  = mk(32'h0,         1, 0, 32'h0,        0, 32'h0,        0, 32'h0,      0, 32'h0,      0, 32'h0,      3);
        // e_valid low with mismatching E inputs: no flush, no allocation
        vecs[6]  = mk(32'h0,         0, 0, 32'h8,        1, 32'h99,       0, 32'h0,      0, 32'h0,      0, 32'h0,      3);
        vecs[7]  = mk(32'h40,        1, 0, 32'h0,        1, 32'h14,       0, 32'h0,      0, 32'h0,      1, 32'h14,     3);
        vecs[8]  = mk(32'h8,         1, 0, 32'h0,        1, 32'h14,       0, 32'h0,      0, 32'h0,      1, 32'h14,     4);
        vecs[9]  = mk(32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1, 32'h14,     0, 32'h0,      5);
        // aliasing allocation at 0x40 evicts the 0x0 entry
        vecs[10] = mk(32'h40,        1, 0, 32'h40,       1, 32'h80,       0, 32'h0,      0, 32'h0,      1, 32'h80,     5);
        vecs[11] = mk(32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      0, 32'h0,      0, 32'h0,      6);
        vecs[12] = mk(32'h40,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1, 32'h80,     0, 32'h0,      6);
        // jalr at 0x8: allocate to 0x20, then retarget to 0x30 (read before write)
        vecs[13] = mk(32'h8,         1, 1, 32'h8,        1, 32'h20,       0, 32'h0,      0, 32'h0,      1, 32'h20,     6);
        vecs[14] = mk(32'h8,         1, 1, 32'h8,        1, 32'h30,       1, 32'h20,     1, 32'h20,     1, 32'h30,     7);
        vecs[15] = mk(32'h8,         0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1, 32'h30,     0, 32'h0,      8);
        // not-taken resolves drop the counter but the jump bit keeps it taken
        vecs[16] = mk(32'h8,         1, 0, 32'h8,        0, 32'h0,        1, 32'h30,     1, 32'h30,     1, 32'hC,      8);
        vecs[17] = mk(32'h8,         1, 0, 32'h8,        0, 32'h0,        1, 32'h30,     1, 32'h30,     1, 32'hC,      9);
        vecs[18] = mk(32'h8,         0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1, 32'h30,     0, 32'h0,     10);
        // fall-through wraps modulo 2^32
        vecs[19] = mk(32'h0,         1, 0, 32'hFFFFFFFC, 0, 32'h0,        1, 32'h100,    0, 32'h0,      1, 32'h0,     10);
        vecs[20] = mk(32'hFFFFFFFC,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      0, 32'h0,      0, 32'h0,     11);

        // ---------------- Reset with mismatching E inputs ----------------
        rst = 1'b0;
        a_f_pc = 32'h0; a_e_valid = 1'b1; a_e_is_jump = 1'b0; a_e_pc = 32'h0;
        a_e_taken = 1'b1; a_e_target = 32'h14; a_e_pred_taken = 1'b0; a_e_pred_target = 32'h0;
        b_f_pc = 32'h0; b_e_valid = 1'b1; b_e_is_jump = 1'b0; b_e_pc = 32'h0;
        b_e_taken = 1'b1; b_e_target = 32'h14; b_e_pred_taken = 1'b0; b_e_pred_target = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_a_pred",     32'(a_f_pred_taken), 32'd0);
        chk("reset_a_ptarget",  a_f_pred_target,     32'd0);
        chk("reset_a_flush",    32'(a_flush),        32'd0);
        chk("reset_a_redirect", a_redirect_pc,       32'd0);
        chk("reset_a_stat",     32'(a_stat),         32'd0);
        chk("reset_b_flush",    32'(b_flush),        32'd0);
        chk("reset_b_stat",     32'(b_stat),         32'd0);
        $display("reset checked");
        a_e_valid = 1'b0;
        b_e_valid = 1'b0;
        rst = 1'b1;

        // ---------------- Table-driven MODE=1 vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1;
            a_f_pc = vecs[i].f_pc;   a_e_valid = vecs[i].ev;  a_e_is_jump = vecs[i].ej;
            a_e_pc = vecs[i].epc;    a_e_taken = vecs[i].et;  a_e_target = vecs[i].etgt;
            a_e_pred_taken = vecs[i].ept; a_e_pred_target = vecs[i].eptgt;
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            x = exp_q.pop_front();
            chk($sformatf("v%0d_pred", i),     32'(a_f_pred_taken), 32'(x.xpt));
            chk($sformatf("v%0d_ptarget", i),  a_f_pred_target,     x.xptgt);
            chk($sformatf("v%0d_flush", i),    32'(a_flush),        32'(x.xfl));
            chk($sformatf("v%0d_redirect", i), a_redirect_pc,       x.xrd);
            chk($sformatf("v%0d_stat", i),     32'(a_stat),         32'(x.xst));
            $display("vec %0d f_pc=%h pred=%b/%h flush=%b redirect=%h stat=%0d",
                     i, a_f_pc, a_f_pred_taken, a_f_pred_target, a_flush, a_redirect_pc, a_stat);
        end
        @(posedge clk);
        #1;
        a_e_valid = 1'b0;
        a_f_pc = 32'h8;

        // ---------------- MODE=0: repeated taken resolve at 0x0 ----------------
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            b_f_pc = 32'h0; b_e_valid = 1'b1; b_e_is_jump = 1'b0; b_e_pc = 32'h0;
            b_e_taken = 1'b1; b_e_target = 32'h14; b_e_pred_taken = 1'b0; b_e_pred_target = 32'h0;
            @(negedge clk);
            chk($sformatf("m0_%0d_pred", k),     32'(b_f_pred_taken), 32'd0);
            chk($sformatf("m0_%0d_ptarget", k),  b_f_pred_target,     32'd0);
            chk($sformatf("m0_%0d_flush", k),    32'(b_flush),        32'd1);
            chk($sformatf("m0_%0d_redirect", k), b_redirect_pc,       32'h14);
            chk($sformatf("m0_%0d_stat", k),     32'(b_stat),         32'(k));
            $display("mode0 resolve %0d flush=%b redirect=%h pred=%b stat=%0d",
                     k, b_flush, b_redirect_pc, b_f_pred_taken, b_stat);
        end
        @(posedge clk);
        #1;
        b_e_valid = 1'b0;
        @(negedge clk);
        chk("m0_stat_saturated", 32'(b_stat),  32'd3);
        chk("m0_idle_flush",     32'(b_flush), 32'd0);
        $display("mode0 idle stat=%0d", b_stat);

        // ---------------- Asynchronous mid-cycle reset ----------------
        a_f_pc = 32'h40; a_e_valid = 1'b1; a_e_pc = 32'h40; a_e_taken = 1'b1;
        a_e_target = 32'h80; a_e_pred_taken = 1'b0; a_e_pred_target = 32'h0;
        #1;
        chk("pre_rst_a_flush", 32'(a_flush),        32'd1);
        chk("pre_rst_a_pred",  32'(a_f_pred_taken), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_b_stat",     32'(b_stat),         32'd0);
        chk("mid_rst_a_stat",     32'(a_stat),         32'd0);
        chk("mid_rst_a_flush",    32'(a_flush),        32'd0);
        chk("mid_rst_a_redirect", a_redirect_pc,       32'd0);
        chk("mid_rst_a_pred",     32'(a_f_pred_taken), 32'd0);
        $display("mid-cycle reset stat_a=%0d stat_b=%0d flush=%b", a_stat, b_stat, a_flush);
        a_e_valid = 1'b0;
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_0x40_pred", 32'(a_f_pred_taken), 32'd0);
        a_f_pc = 32'h8;
        #1;
        chk("post_rst_0x8_pred",  32'(a_f_pred_taken), 32'd0);
        chk("post_rst_0x8_ptgt",  a_f_pred_target,     32'd0);
        a_f_pc = 32'hFFFFFFFC;
        #1;
        chk("post_rst_wrap_pred", 32'(a_f_pred_taken), 32'd0);
        chk("post_rst_a_stat",    32'(a_stat),         32'd0);
        $display("post-reset lookups done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
